// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with edge-latched requests,
// per-channel mask, in-service tracking, EOI port commands and a
// minimum spacing (HOLD) between deliveries signalled by an irq toggle.
// Optional build macro IRQ_NESTED_EN: allow a higher-priority channel to
// preempt one already in service (fully nested mode).
module irq_ctrl #(
    parameter int CHANNELS    = 8,
    parameter int VECTOR_BASE = 8,
    parameter int HOLD        = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] req,
    input  logic [15:0]         port_a,
    input  logic                port_w,
    input  logic                port_r,
    input  logic [7:0]          port_o,
    output logic [7:0]          port_i,
    output logic                irq,
    output logic [7:0]          irq_in,
    output logic [CHANNELS-1:0] isr
);

    // State is kept 16 bits wide internally; bits at or above CHANNELS are
    // forced to zero so the port read mux needs no per-width special cases.
    localparam logic [15:0] CH_MASK = 16'((32'd1 << CHANNELS) - 32'd1);
    localparam logic [7:0]  VB8     = 8'(VECTOR_BASE);
    localparam logic [3:0]  HOLD_LD = 4'(HOLD - 1);

    logic [15:0] irr_q, isr_q, mask_q;
    logic [3:0]  hold_q;

    logic [15:0] req16, eligible;
    logic [15:0] irr_next, isr_next, mask_next;
    logic [15:0] deliver_set, eoi_clear;
    logic [3:0]  win_idx, isr_low;
    logic        win_any, isr_any, permit, deliver;
    logic [7:0]  rd_data;
    logic        rd_hit;

    assign isr = isr_q[CHANNELS-1:0];

    // Priority resolution, delivery decision and next-state computation.
    always_comb begin
        req16 = '0;
        req16[CHANNELS-1:0] = req;
        eligible = irr_q & ~mask_q;

        win_any = 1'b0;
        win_idx = '0;
        isr_any = 1'b0;
        isr_low = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (eligible[i] && !win_any) begin
                win_any = 1'b1;
                win_idx = 4'(i);
            end
            if (isr_q[i] && !isr_any) begin
                isr_any = 1'b1;
                isr_low = 4'(i);
            end
        end

`ifdef IRQ_NESTED_EN
        permit = !isr_any || (win_idx < isr_low);
`else
        permit = !isr_any;
`endif
        deliver     = win_any && permit && (hold_q == '0);
        deliver_set = deliver ? (16'd1 << win_idx) : '0;

        eoi_clear = '0;
        if (port_w && port_a == 16'h0020) begin
            if (port_o == 8'h20) begin
                if (isr_any) eoi_clear = 16'd1 << isr_low;
            end else if (port_o[7:4] == 4'h6) begin
                eoi_clear = 16'd1 << port_o[3:0];
            end
        end

        mask_next = mask_q;
        if (port_w && port_a == 16'h0021) mask_next[7:0]  = port_o;
        if (port_w && port_a == 16'h00A1) mask_next[15:8] = port_o;
        mask_next = mask_next & CH_MASK;

        // A request arriving on the delivery edge of the same channel wins.
        irr_next = ((irr_q & ~deliver_set) | req16) & CH_MASK;
        // EOI clears first, then the delivery sets its bit.
        isr_next = ((isr_q & ~eoi_clear) | deliver_set) & CH_MASK;

        rd_hit  = 1'b1;
        rd_data = '0;
        case (port_a)
            16'h0020: rd_data = irr_q[7:0];
            16'h00A0: rd_data = irr_q[15:8];
            16'h0021: rd_data = mask_q[7:0];
            16'h00A1: rd_data = mask_q[15:8];
            16'h0022: rd_data = isr_q[7:0];
            16'h00A2: rd_data = isr_q[15:8];
            default:  rd_hit  = 1'b0;
        endcase
    end

    // Controller state, delivery outputs and registered read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irr_q  <= '0;
            isr_q  <= '0;
            mask_q <= '0;
            hold_q <= '0;
            irq    <= 1'b0;
            irq_in <= VB8;
            port_i <= '0;
        end else begin
            irr_q  <= irr_next;
            isr_q  <= isr_next;
            mask_q <= mask_next;
            if (deliver) begin
                irq    <= ~irq;
                irq_in <= VB8 + {4'd0, win_idx};
                hold_q <= HOLD_LD;
            end else if (hold_q != '0) begin
                hold_q <= hold_q - 4'd1;
            end
            if (port_r && rd_hit) port_i <= rd_data;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: an 8-channel default instance and a
// 16-channel instance with VECTOR_BASE=250 sharing clock, reset and port bus.
module tb_irq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  a_req;
    logic [15:0] b_req;
    logic [15:0] port_a;
    logic        port_w, port_r;
    logic [7:0]  port_o;
    logic [7:0]  a_port_i, b_port_i;
    logic        a_irq, b_irq;
    logic [7:0]  a_irq_in, b_irq_in;
    logic [7:0]  a_isr;
    logic [15:0] b_isr;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_irq;

    always #5 clock = ~clock;

    irq_ctrl u_a (
        .clock(clock), .reset_n(reset_n), .req(a_req),
        .port_a(port_a), .port_w(port_w), .port_r(port_r), .port_o(port_o),
        .port_i(a_port_i), .irq(a_irq), .irq_in(a_irq_in), .isr(a_isr)
    );

    irq_ctrl #(.CHANNELS(16), .VECTOR_BASE(250)) u_b (
        .clock(clock), .reset_n(reset_n), .req(b_req),
        .port_a(port_a), .port_w(port_w), .port_r(port_r), .port_o(port_o),
        .port_i(b_port_i), .irq(b_irq), .irq_in(b_irq_in), .isr(b_isr)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port_a = a;
        port_o = d;
        port_w = 1'b1;
        tick();
        port_w = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        port_a = a;
        port_r = 1'b1;
        tick();
        port_r = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = '0;
        b_req = '0;
        port_a = '0;
        port_w = 1'b0;
        port_r = 1'b0;
        port_o = '0;
        exp_irq = 1'b0;
        tick();
        tick();

        // reset values
        chk("rst_irq", a_irq, 0);
        chk("rst_irq_in", a_irq_in, 8);
        chk("rst_port_i", a_port_i, 0);
        chk("rst_isr", a_isr, 0);
        chk("rst_b_irq_in", b_irq_in, 250);
        reset_n = 1'b1;
        idle(2);

        // single request on channel 1
        a_req = 8'h02;
        tick();
        a_req = '0;
        chk("s1_no_early_irq", a_irq, exp_irq);
        rd(16'h0020);
        chk("s1_irr_read", a_port_i, 8'h02);
        exp_irq = ~exp_irq;
        chk("s1_irq", a_irq, exp_irq);
        chk("s1_irq_in", a_irq_in, 9);
        chk("s1_isr", a_isr, 8'h02);
        wr(16'h0020, 8'h20);
        chk("s1_eoi", a_isr, 0);
        idle(4);

        // two simultaneous requests: priority, then HOLD spacing after EOI
        a_req = 8'h06;
        tick();
        a_req = '0;
        tick();
        exp_irq = ~exp_irq;
        chk("s2_irq1", a_irq, exp_irq);
        chk("s2_irq_in1", a_irq_in, 9);
        chk("s2_isr1", a_isr, 8'h02);
        wr(16'h0020, 8'h20);
        chk("s2_eoi", a_isr, 0);
        chk("s2_hold_a", a_irq, exp_irq);
        tick();
        chk("s2_hold_b", a_irq, exp_irq);
        tick();
        chk("s2_hold_c", a_irq, exp_irq);
        tick();
        exp_irq = ~exp_irq;
        chk("s2_irq2", a_irq, exp_irq);
        chk("s2_irq_in2", a_irq_in, 10);
        chk("s2_isr2", a_isr, 8'h04);
        wr(16'h0020, 8'h20);
        idle(4);

        // channel 3 in service, then channel 0 requested
        a_req = 8'h08;
        tick();
        a_req = '0;
        tick();
        exp_irq = ~exp_irq;
        chk("s3_irq3", a_irq, exp_irq);
        chk("s3_irq_in3", a_irq_in, 11);
        chk("s3_isr3", a_isr, 8'h08);
        idle(4);
        a_req = 8'h01;
        tick();
        a_req = '0;
        tick();
`ifdef IRQ_NESTED_EN
        exp_irq = ~exp_irq;
        chk("s3_nest_irq", a_irq, exp_irq);
        chk("s3_nest_irq_in", a_irq_in, 8);
        chk("s3_nest_isr", a_isr, 8'h09);
        wr(16'h0020, 8'h20);
        chk("s3_nest_eoi0", a_isr, 8'h08);
        wr(16'h0020, 8'h63);
        chk("s3_nest_eoi3", a_isr, 0);
        tick();
        chk("s3_nest_quiet", a_irq, exp_irq);
`else
        chk("s3_blocked_irq", a_irq, exp_irq);
        chk("s3_blocked_isr", a_isr, 8'h08);
        tick();
        chk("s3_blocked_irq2", a_irq, exp_irq);
        wr(16'h0020, 8'h63);
        chk("s3_eoi3", a_isr, 0);
        chk("s3_eoi_edge_irq", a_irq, exp_irq);
        tick();
        exp_irq = ~exp_irq;
        chk("s3_irq0", a_irq, exp_irq);
        chk("s3_irq_in0", a_irq_in, 8);
        chk("s3_isr0", a_isr, 8'h01);
        wr(16'h0020, 8'h20);
        chk("s3_eoi0", a_isr, 0);
`endif
        idle(4);

        // masking holds a request pending without clearing it
        wr(16'h0021, 8'h01);
        a_req = 8'h01;
        tick();
        a_req = '0;
        idle(2);
        chk("s4_masked_irq", a_irq, exp_irq);
        chk("s4_masked_isr", a_isr, 0);
        rd(16'h0020);
        chk("s4_irr_kept", a_port_i, 8'h01);
        rd(16'h0021);
        chk("s4_mask_read", a_port_i, 8'h01);
        rd(16'h1234);
        chk("s4_bad_addr_hold", a_port_i, 8'h01);
        wr(16'h0021, 8'h00);
        chk("s4_unmask_edge", a_irq, exp_irq);
        tick();
        exp_irq = ~exp_irq;
        chk("s4_irq", a_irq, exp_irq);
        chk("s4_irq_in", a_irq_in, 8);
        chk("s4_isr", a_isr, 8'h01);
        wr(16'h0020, 8'h6A);
        chk("s4_eoi_nochan", a_isr, 8'h01);
        wr(16'h0020, 8'h55);
        chk("s4_eoi_ignored", a_isr, 8'h01);
        rd(16'h0022);
        chk("s4_isr_read", a_port_i, 8'h01);
        wr(16'h0020, 8'h20);
        chk("s4_eoi", a_isr, 0);
        wr(16'h00A1, 8'hFF);
        rd(16'h00A1);
        chk("s4_mask_hi_absent", a_port_i, 0);
        rd(16'h00A0);
        chk("s4_irr_hi_absent", a_port_i, 0);
        idle(4);

        // reset while a request is pending
        a_req = 8'h04;
        tick();
        a_req = '0;
        tick();
        exp_irq = ~exp_irq;
        chk("s5_irq", a_irq, exp_irq);
        chk("s5_irq_in", a_irq_in, 10);
        a_req = 8'h02;
        tick();
        a_req = '0;
        reset_n = 1'b0;
        #1;
        exp_irq = 1'b0;
        chk("s5_rst_irq", a_irq, 0);
        chk("s5_rst_irq_in", a_irq_in, 8);
        chk("s5_rst_isr", a_isr, 0);
        a_req = 8'h01;
        tick();
        a_req = '0;
        tick();
        reset_n = 1'b1;
        idle(6);
        chk("s5_post_irq", a_irq, 0);
        chk("s5_post_isr", a_isr, 0);
        rd(16'h0020);
        chk("s5_post_irr", a_port_i, 0);

        // 16 channels, vector wrap
        b_req = 16'h0400;
        tick();
        b_req = '0;
        tick();
        chk("s6_irq", b_irq, 1);
        chk("s6_irq_in_wrap", b_irq_in, 4);
        chk("s6_isr", b_isr, 16'h0400);
        rd(16'h00A2);
        chk("s6_isr_hi_read", b_port_i, 8'h04);
        wr(16'h0020, 8'h6A);
        chk("s6_eoi10", b_isr, 0);
        rd(16'h00A2);
        chk("s6_isr_hi_clear", b_port_i, 0);
        wr(16'h00A1, 8'h80);
        rd(16'h00A1);
        chk("s6_mask_hi", b_port_i, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter CHANNELS, default 8, number of request lines; legal range 1..16.
REQ-002 Parameter VECTOR_BASE, default 8, vector number of channel 0.
REQ-003 Parameter HOLD, default 4, minimum number of clock cycles between two deliveries; legal range 1..15.
REQ-004 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req, input, CHANNELS bits: one-cycle request pulses; bit 0 has the highest priority.
REQ-007 Port port_a, input, 16 bits: I/O port address.
REQ-008 Port port_w, input, 1 bit: I/O write strobe.
REQ-009 Port port_r, input, 1 bit: I/O read strobe.
REQ-010 Port port_o, input, 8 bits: write data from the CPU.
REQ-011 Port port_i, output, 8 bits: registered read data to the CPU.
REQ-012 Port irq, output, 1 bit: toggle-style interrupt signal to the core.
REQ-013 Port irq_in, output, 8 bits: vector number, valid from the toggle onward.
REQ-014 Port isr, output, CHANNELS bits: in-service register, for debug.

Function
REQ-015 A req bit sampled high at edge E SHALL set the matching IRR bit after E; requests are edge-latched and not counted, so repeats while the bit is already set are lost.
REQ-016 Eligible set = IRR & ~mask; the winner is the lowest-index eligible bit.
REQ-017 A delivery SHALL occur at the edge after the eligible set becomes non-empty, provided the hold counter is zero and the in-service rule (REQ-024/025) permits it.
- Delivery actions, all at the same edge: irq toggles; irq_in <= (VECTOR_BASE + n) mod 256; IRR[n] cleared; ISR[n] set; hold counter loaded with HOLD-1.
REQ-018 The hold counter SHALL decrement to zero, one per cycle; no delivery occurs while it is non-zero.
REQ-019 If req[n] is high at the same edge that delivers channel n, IRR[n] SHALL remain set.
REQ-020 Port writes, address decode on all 16 bits:
- 0x0020 data 0x20: non-specific EOI; clears the lowest-index set ISR bit.
- 0x0020 data 0x60..0x6F: specific EOI; clears ISR[data[3:0]] if that channel exists, otherwise no effect.
- 0x0021: mask[7:0] <= port_o.
- 0x00A1: mask[15:8] <= port_o, for bits below CHANNELS only.
- Other data written to 0x0020 is ignored.
REQ-021 Port reads SHALL load port_i on the strobe edge; port_i holds its value otherwise.
- 0x0020: IRR[7:0]
- 0x00A0: IRR[15:8]
- 0x0021: mask[7:0]
- 0x00A1: mask[15:8]
- 0x0022: ISR[7:0]
- 0x00A2: ISR[15:8]
- Bits at or above CHANNELS read as 0.
- Any other address leaves port_i unchanged.
REQ-022 An EOI and a delivery at the same edge SHALL both take effect: the EOI clears first, then the delivery sets its ISR bit.
REQ-023 A mask change SHALL affect eligibility from the next cycle; masking does not clear IRR.

Reset
REQ-026 While reset_n is low, the block SHALL hold: irq=0, irq_in=VECTOR_BASE, port_i=0, IRR=0, ISR=0, mask=0 (all channels enabled), hold counter=0.
REQ-027 Deassertion mid-operation SHALL leave no pending or in-service state; requests that arrive during reset are dropped.

Configuration
REQ-024 With macro IRQ_NESTED_EN defined, a delivery SHALL be permitted when the winner index is lower than the lowest set ISR bit, or when ISR=0 (fully nested preemption).
REQ-025 Without IRQ_NESTED_EN, a delivery SHALL be permitted only when ISR=0, so at most one channel is in service at a time.

Verification
REQ-028 Bench SHALL cover these directed scenarios:
- req[1] pulse at edge 10, defaults -> IRR[1] set after edge 10; irq toggles and irq_in=9 after edge 11; ISR=0x02.
- req=0x06 in one cycle -> channel 1 delivered (irq_in=9); channel 2 delivered only after write 0x20->0x0020 and expiry of HOLD, with irq_in=10.
- IRQ_NESTED_EN, channel 3 in service, req[0] pulse -> irq toggles, irq_in=8, ISR=0x09; without the macro no toggle until EOI.
- write 0x01->0x0021, req[0] pulse -> no toggle, IRR[0] still set; write 0x00->0x0021 -> delivery with irq_in=8 two edges later.
- CHANNELS=16, VECTOR_BASE=250, req[10] -> irq_in=4 (wrap); write 0x6A->0x0020 clears ISR[10]; read 0x00A2 returns 0x00.
- reset_n low between a request and its delivery -> no toggle after release; IRR=ISR=0; irq=0.
